// File: rtl/pwm_fader_multi_pkg.sv
// Shared definitions for the multi-channel PWM fader: defaults, level names,
// fade direction type and the channel-index width helper.
package pwm_pkg;

  localparam int NCH_DEF      = 3;
  localparam int W_DEF        = 8;
  localparam int STEP_DEF     = 3;
  localparam int DIV_BITS_DEF = 18;

  // Named colour levels at the default resolution.
  localparam logic [W_DEF-1:0] LVL_OFF  = '0;
  localparam logic [W_DEF-1:0] LVL_FULL = '1;

  typedef enum logic [1:0] {
    FADE_HOLD = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } fade_dir_e;

  // A single channel still needs a one-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_fader_multi_chan.sv
// One PWM channel: target/current levels, fade stepping on the shared tick,
// shadow duty latched at the period boundary and the registered comparator.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int STEP = STEP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         boundary,
  input  logic [W-1:0] cnt,
  input  logic         wr_hit,
  input  logic         wr_instant,
  input  logic [W-1:0] wr_level,
  output logic         pwm,
  output logic         busy
);

  localparam logic [W:0]   STEP_X = (W+1)'(STEP);
  localparam logic [W-1:0] FULL   = '1;

  logic [W-1:0] tgt_reg;
  logic [W-1:0] cur_reg;
  logic [W-1:0] duty_reg;
  logic         pwm_reg;

  logic [W-1:0] cur_next;
  logic         pwm_next;
  fade_dir_e    dir;
  logic [W:0]   gap;
  logic [W:0]   step_amt;
  logic [W:0]   sum;

  // Fade step is computed against the target held before any same-cycle write.
  always_comb begin
    dir      = FADE_HOLD;
    gap      = '0;
    sum      = {1'b0, cur_reg};
    cur_next = cur_reg;
    if (cur_reg < tgt_reg) begin
      dir = FADE_UP;
      gap = {1'b0, tgt_reg} - {1'b0, cur_reg};
    end else if (cur_reg > tgt_reg) begin
      dir = FADE_DOWN;
      gap = {1'b0, cur_reg} - {1'b0, tgt_reg};
    end
    step_amt = (gap > STEP_X) ? STEP_X : gap;
    case (dir)
      FADE_UP:   sum = {1'b0, cur_reg} + step_amt;
      FADE_DOWN: sum = {1'b0, cur_reg} - step_amt;
      default:   sum = {1'b0, cur_reg};
    endcase
    if (wr_hit && wr_instant) begin
      cur_next = wr_level;
    end else if (tick) begin
      cur_next = sum[W-1:0];
    end
  end

  always_comb begin
    pwm_next = 1'b0;
    if (duty_reg == FULL) begin
      pwm_next = 1'b1;
    end else if (duty_reg != '0) begin
      pwm_next = (cnt < duty_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_reg  <= '0;
      cur_reg  <= '0;
      duty_reg <= '0;
      pwm_reg  <= 1'b0;
    end else begin
      if (wr_hit) begin
        tgt_reg <= wr_level;
      end
      cur_reg <= cur_next;
      if (boundary) begin
        duty_reg <= cur_reg;
      end
      pwm_reg <= pwm_next;
    end
  end

  assign pwm  = pwm_reg;
  assign busy = (cur_reg != tgt_reg);

endmodule

// File: rtl/pwm_fader_multi.sv
// Multi-channel LED PWM driver with per-channel fade engines; the PWM counter
// and fade-tick prescaler are shared by all channels.
module pwm_fader_multi
  import pwm_pkg::*;
#(
  parameter int  NCH      = NCH_DEF,
  parameter int  W        = W_DEF,
  parameter int  STEP     = STEP_DEF,
  parameter int  DIV_BITS = DIV_BITS_DEF,
  localparam int CHW      = clog2_min1(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [W-1:0]   wr_level,
  input  logic           wr_instant,
  output logic [NCH-1:0] pwm_o,
  output logic           fading,
  output logic           fade_done
);

  logic [W-1:0]        cnt_reg;
  logic [DIV_BITS-1:0] presc_reg;
  logic                fading_reg;
  logic                fade_done_reg;

  logic                tick;
  logic                boundary;
  logic                wr_valid;
  logic [NCH-1:0]      busy;
  logic [NCH-1:0]      pwm_vec;
  logic                any_busy;

  assign tick     = (presc_reg == '0);
  assign boundary = (cnt_reg == '1);
  // Out-of-range channel indices are dropped without touching any state.
  assign wr_valid = wr_en && (int'(wr_ch) < NCH);
  assign any_busy = |busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      presc_reg     <= '0;
      fading_reg    <= 1'b0;
      fade_done_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_reg + W'(1);
      presc_reg     <= presc_reg + DIV_BITS'(1);
      fading_reg    <= any_busy;
      fade_done_reg <= fading_reg && !any_busy;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic chan_wr;
    assign chan_wr = wr_valid && (wr_ch == CHW'(gi));

    pwm_chan #(
      .W    (W),
      .STEP (STEP)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .boundary   (boundary),
      .cnt        (cnt_reg),
      .wr_hit     (chan_wr),
      .wr_instant (wr_instant),
      .wr_level   (wr_level),
      .pwm        (pwm_vec[gi]),
      .busy       (busy[gi])
    );
  end

  assign pwm_o     = pwm_vec;
  assign fading    = fading_reg;
  assign fade_done = fade_done_reg;

endmodule

// File: tb/tb_pwm_fader_multi.sv
// Scoreboard bench for pwm_fader_multi: stimulus queues timed expectations,
// a monitor pops and compares them against the DUT state after each edge.
module tb_pwm_fader_multi;
  import pwm_pkg::*;

  localparam int NCH      = 3;
  localparam int W        = 8;
  localparam int STEP     = 3;
  localparam int DIV_BITS = 4;
  localparam int CHW      = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [W-1:0]   wr_level = '0;
  logic           wr_instant = 1'b0;
  logic [NCH-1:0] pwm_o;
  logic           fading;
  logic           fade_done;

  pwm_fader_multi #(
    .NCH      (NCH),
    .W        (W),
    .STEP     (STEP),
    .DIV_BITS (DIV_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_level   (wr_level),
    .wr_instant (wr_instant),
    .pwm_o      (pwm_o),
    .fading     (fading),
    .fade_done  (fade_done)
  );

  typedef enum int {K_PWM, K_FADING, K_DONE, K_LEVEL, K_TARGET, K_HI, K_DONECNT} kind_e;
  typedef struct {
    longint at;
    kind_e  kind;
    int     idx;
    int     exp;
    string  name;
  } exp_t;

  exp_t   sb_q[$];
  longint now = 0;
  longint base = 0;
  int     checks = 0;
  int     failures = 0;
  int     done_cnt = 0;
  int     acc[NCH];
  int     hi_last[NCH];
  bit     stim_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) now <= now + 1;

  function automatic longint cyc();
    return now - base;
  endfunction

  // Advance to the falling edge where cyc()==c; write strobes last one cycle.
  task automatic goto(input longint c);
    while (cyc() < c) begin
      @(negedge clk);
      wr_en      = 1'b0;
      wr_instant = 1'b0;
    end
  endtask

  task automatic expect_next(input kind_e k, input int idx, input int exp, input string name);
    exp_t e;
    e.at = now + 1; e.kind = k; e.idx = idx; e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic chk_at(input longint c, input kind_e k, input int idx, input int exp, input string name);
    goto(c - 1);
    expect_next(k, idx, exp, name);
  endtask

  task automatic write(input longint c, input int ch, input int lvl, input bit inst);
    goto(c);
    wr_en      = 1'b1;
    wr_ch      = CHW'(ch);
    wr_level   = W'(lvl);
    wr_instant = inst;
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    int act;
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      acc[i] = 0;
      hi_last[i] = -1;
    end
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        for (int i = 0; i < NCH; i++) acc[i] = 0;
      end else begin
        for (int i = 0; i < NCH; i++) acc[i] += int'(pwm_o[i]);
        if (cyc() > 0 && (cyc() % 256) == 0) begin
          for (int i = 0; i < NCH; i++) begin
            hi_last[i] = acc[i];
            acc[i] = 0;
          end
        end
      end
      if (fade_done) done_cnt++;
      while (sb_q.size() > 0 && sb_q[0].at <= now) begin
        e = sb_q.pop_front();
        case (e.kind)
          K_PWM:    act = int'(pwm_o);
          K_FADING: act = int'(fading);
          K_DONE:   act = int'(fade_done);
          K_LEVEL: begin
            case (e.idx)
              0:       act = int'(dut.g_ch[0].u_chan.cur_reg);
              1:       act = int'(dut.g_ch[1].u_chan.cur_reg);
              default: act = int'(dut.g_ch[2].u_chan.cur_reg);
            endcase
          end
          K_TARGET: begin
            case (e.idx)
              0:       act = int'(dut.g_ch[0].u_chan.tgt_reg);
              1:       act = int'(dut.g_ch[1].u_chan.tgt_reg);
              default: act = int'(dut.g_ch[2].u_chan.tgt_reg);
            endcase
          end
          K_HI:    act = hi_last[e.idx];
          default: act = done_cnt;
        endcase
        checks++;
        if (e.at != now || act != e.exp) begin
          failures++;
          $display("FAIL %s: actual=%0d required=%0d (due %0d, checked %0d)",
                   e.name, act, e.exp, e.at, now);
        end
      end
      if (stim_done || now > 60000) begin
        if (!stim_done) begin
          failures++;
          $display("FAIL watchdog: actual=timeout required=stimulus complete");
        end
        while (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++;
          failures++;
          $display("FAIL %s: actual=unchecked required=%0d", e.name, e.exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    // Reset held for three rising edges.
    repeat (3) @(negedge clk);
    expect_next(K_PWM, 0, 0, "rst_pwm");
    expect_next(K_FADING, 0, 0, "rst_fading");
    expect_next(K_DONE, 0, 0, "rst_done");
    expect_next(K_LEVEL, 0, 0, "rst_level0");
    expect_next(K_TARGET, 2, 0, "rst_target2");
    @(negedge clk);
    rst  = 1'b0;
    base = now;

    // Idle for three periods.
    chk_at(100, K_PWM, 0, 0, "idle_pwm");
    chk_at(768, K_HI, 0, 0, "idle_hi0");
    expect_next(K_HI, 1, 0, "idle_hi1");
    expect_next(K_HI, 2, 0, "idle_hi2");
    expect_next(K_FADING, 0, 0, "idle_fading");
    expect_next(K_DONECNT, 0, 0, "idle_donecnt");

    // Instant duty levels on ch0.
    write(770, 0, 64, 1'b1);
    expect_next(K_LEVEL, 0, 64, "inst64_level");
    expect_next(K_FADING, 0, 0, "inst64_fading");
    chk_at(1024, K_HI, 0, 0, "inst64_prev_period");
    chk_at(1280, K_HI, 0, 64, "inst64_hi");
    write(1290, 0, int'(LVL_FULL), 1'b1);
    chk_at(1700, K_PWM, 0, 1, "full_pwm_vec");
    chk_at(1792, K_HI, 0, 256, "full_hi");
    write(1800, 0, int'(LVL_OFF), 1'b1);
    chk_at(2048, K_HI, 0, 256, "off_prev_period");
    chk_at(2304, K_HI, 0, 0, "off_hi");
    write(2310, 0, 1, 1'b1);
    chk_at(2816, K_HI, 0, 1, "one_hi");
    write(2820, 0, 0, 1'b1);

    // Fade ch1 up to 10: steps 3,6,9,10.
    write(2900, 1, 10, 1'b0);
    chk_at(2901, K_FADING, 0, 0, "up_fading_lat");
    chk_at(2902, K_FADING, 0, 1, "up_fading");
    chk_at(2912, K_LEVEL, 1, 0, "up_l0");
    chk_at(2913, K_LEVEL, 1, 3, "up_l3");
    chk_at(2929, K_LEVEL, 1, 6, "up_l6");
    chk_at(2945, K_LEVEL, 1, 9, "up_l9");
    chk_at(2961, K_LEVEL, 1, 10, "up_l10");
    expect_next(K_FADING, 0, 1, "up_fading_last");
    chk_at(2962, K_FADING, 0, 0, "up_fading_end");
    expect_next(K_DONE, 0, 1, "up_done_pulse");
    chk_at(2963, K_DONE, 0, 0, "up_done_end");
    chk_at(2970, K_DONECNT, 0, 1, "up_donecnt");

    // Opposite full-scale fades on ch0/ch2, short fade on ch1.
    write(3000, 0, 255, 1'b1);
    write(3001, 2, 255, 1'b0);
    write(3002, 0, 0, 1'b0);
    expect_next(K_TARGET, 2, 255, "multi_tgt2");
    write(3003, 1, 13, 1'b0);
    chk_at(3009, K_LEVEL, 0, 252, "multi_l0_first");
    expect_next(K_LEVEL, 1, 13, "multi_l1_first");
    expect_next(K_LEVEL, 2, 3, "multi_l2_first");
    chk_at(4352, K_LEVEL, 0, 3, "multi_l0_84");
    expect_next(K_LEVEL, 2, 252, "multi_l2_84");
    expect_next(K_DONECNT, 0, 1, "multi_no_early_done");
    chk_at(4353, K_LEVEL, 0, 0, "multi_l0_end");
    expect_next(K_LEVEL, 2, 255, "multi_l2_end");
    expect_next(K_FADING, 0, 1, "multi_fading_last");
    chk_at(4354, K_FADING, 0, 0, "multi_fading_end");
    expect_next(K_DONE, 0, 1, "multi_done_pulse");
    chk_at(4355, K_DONE, 0, 0, "multi_done_end");
    chk_at(4360, K_DONECNT, 0, 2, "multi_donecnt");
    chk_at(4864, K_HI, 0, 0, "multi_hi0");
    expect_next(K_HI, 1, 13, "multi_hi1");
    expect_next(K_HI, 2, 256, "multi_hi2");

    // Writes colliding with fade ticks, then an out-of-range channel.
    write(4900, 0, 50, 1'b1);
    write(4901, 0, 54, 1'b0);
    chk_at(4913, K_LEVEL, 0, 53, "col_pre");
    write(4928, 0, 100, 1'b0);
    expect_next(K_LEVEL, 0, 54, "col_old_target_step");
    expect_next(K_TARGET, 0, 100, "col_new_target");
    chk_at(4945, K_LEVEL, 0, 57, "col_after");
    write(4960, 2, 7, 1'b1);
    expect_next(K_LEVEL, 0, 60, "col_other_fades");
    expect_next(K_LEVEL, 2, 7, "col_instant_level");
    expect_next(K_TARGET, 2, 7, "col_instant_target");
    write(4970, 3, 200, 1'b1);
    expect_next(K_LEVEL, 0, 60, "bad_l0");
    expect_next(K_LEVEL, 1, 13, "bad_l1");
    expect_next(K_LEVEL, 2, 7, "bad_l2");
    expect_next(K_TARGET, 0, 100, "bad_t0");
    expect_next(K_TARGET, 1, 13, "bad_t1");
    expect_next(K_TARGET, 2, 7, "bad_t2");
    expect_next(K_FADING, 0, 1, "bad_fading");
    expect_next(K_DONECNT, 0, 2, "bad_donecnt");

    // Retarget ch0 to 120 -> 200, then reset mid-fade.
    write(4980, 0, 120, 1'b1);
    write(4981, 0, 200, 1'b0);
    expect_next(K_DONE, 0, 1, "settle_done_pulse");
    expect_next(K_FADING, 0, 0, "settle_fading");
    chk_at(4983, K_FADING, 0, 1, "refade_fading");
    chk_at(4990, K_DONECNT, 0, 3, "refade_donecnt");
    chk_at(4991, K_LEVEL, 0, 120, "prerst_level");
    expect_next(K_TARGET, 0, 200, "prerst_target");
    goto(4991);
    rst = 1'b1;
    expect_next(K_LEVEL, 0, 0, "midrst_level");
    expect_next(K_TARGET, 0, 0, "midrst_target");
    expect_next(K_PWM, 0, 0, "midrst_pwm");
    expect_next(K_FADING, 0, 0, "midrst_fading");
    expect_next(K_DONE, 0, 0, "midrst_done");
    @(negedge clk);
    rst = 1'b0;
    expect_next(K_DONE, 0, 0, "postrst_done");
    expect_next(K_FADING, 0, 0, "postrst_fading");
    expect_next(K_LEVEL, 0, 0, "postrst_level");
    @(negedge clk);
    expect_next(K_DONE, 0, 0, "postrst_done2");
    expect_next(K_DONECNT, 0, 3, "postrst_donecnt");
    repeat (3) @(negedge clk);
    stim_done = 1'b1;
  end

endmodule
